cacheline_adapter: RTL and testbench

Bridges the cache's 256-bit line port (dfp_*) to the 64-bit burst memory (bmem_*), sitting directly downstream of the cache. A line read becomes one burst read request plus four collected data beats. A line write (dirty eviction) becomes four consecutive write beats. Exactly one transfer is in flight at a time, and each one is acknowledged to the cache with a single-cycle dfp_resp.

---
 rtl/cacheline_adapter_pkg.sv | 21 ++
 rtl/cacheline_adapter_line_buf.sv | 21 ++
 rtl/cacheline_adapter.sv | 138 +++++++++++++
 tb/tb_cacheline_adapter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cacheline_adapter_pkg.sv
// Shared widths and FSM state type for the cache-line to burst-memory adapter.
package cacheline_adapter_pkg;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = LINE_W / BEAT_W;
    localparam int CNT_W  = $clog2(BEATS);
    localparam int OFF_W  = $clog2(LINE_W / 8);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_BEAT,
        RESP
    } state_t;

endpackage

// File: rtl/cacheline_adapter_line_buf.sv
// Line register assembled from beat-indexed writes; module name cla_line_buf.
module cla_line_buf
    import cacheline_adapter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CNT_W-1:0]  wr_idx,
    input  logic [BEAT_W-1:0] wr_data,
    output logic [LINE_W-1:0] line
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            line <= '0;
        end else if (wr_en) begin
            line[wr_idx*BEAT_W +: BEAT_W] <= wr_data;
        end
    end

endmodule

// File: rtl/cacheline_adapter.sv
// Bridges a 256-bit cache line port to a 64-bit burst memory, one transfer at a time.
// Optional build macro CLA_RADDR_CHECK_EN: drop read beats whose burst tag mismatches and raise sticky err.
//
// state   | meaning
// IDLE    | waiting for a line request; write wins over read
// RD_REQ  | burst read request presented until memory accepts it
// RD_DATA | collecting four read beats into the line buffer
// WR_BEAT | presenting four write beats, advancing on bmem_ready
// RESP    | one-cycle dfp_resp, then back to IDLE
module cacheline_adapter
    import cacheline_adapter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       dfp_addr,
    input  logic              dfp_read,
    input  logic              dfp_write,
    input  logic [LINE_W-1:0] dfp_wdata,
    output logic [LINE_W-1:0] dfp_rdata,
    output logic              dfp_resp,
    output logic [31:0]       bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [31:0]       bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid,
    output logic              err
);

    state_t                    state;
    state_t                    state_nx;
    logic [CNT_W-1:0]          cnt;
    logic [ADDR_W-1:OFF_W]     line_addr;
    logic                      raddr_ok;
    logic                      beat_ok;
    logic                      wr_acc;
    logic                      unused_dfp_lo;

    assign unused_dfp_lo = ^dfp_addr[OFF_W-1:0];

`ifdef CLA_RADDR_CHECK_EN
    logic err_q;
    logic unused_raddr_lo;

    assign unused_raddr_lo = ^bmem_raddr[OFF_W-1:0];
    assign raddr_ok        = (bmem_raddr[ADDR_W-1:OFF_W] == line_addr);

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (state == RD_DATA && bmem_rvalid && !raddr_ok) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_raddr;

    assign unused_raddr = ^bmem_raddr;
    assign raddr_ok     = 1'b1;
    assign err          = 1'b0;
`endif

    assign beat_ok = (state == RD_DATA) && bmem_rvalid && raddr_ok;
    assign wr_acc  = (state == WR_BEAT) && bmem_ready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (dfp_write) begin
                    state_nx = WR_BEAT;
                end else if (dfp_read) begin
                    state_nx = RD_REQ;
                end
            end
            RD_REQ: begin
                if (bmem_ready) begin
                    state_nx = RD_DATA;
                end
            end
            RD_DATA: begin
                if (beat_ok && cnt == LAST_BEAT) begin
                    state_nx = RESP;
                end
            end
            WR_BEAT: begin
                if (wr_acc && cnt == LAST_BEAT) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            line_addr <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && (dfp_write || dfp_read)) begin
                line_addr <= dfp_addr[ADDR_W-1:OFF_W];
            end
            // The counter restarts on every burst entry so a stale count never leaks across transfers.
            if (state_nx != state && (state_nx == RD_DATA || state_nx == WR_BEAT)) begin
                cnt <= '0;
            end else if (beat_ok || wr_acc) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    cla_line_buf u_rd_line (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (beat_ok),
        .wr_idx  (cnt),
        .wr_data (bmem_rdata),
        .line    (dfp_rdata)
    );

    assign dfp_resp   = (state == RESP);
    assign bmem_read  = (state == RD_REQ);
    assign bmem_write = (state == WR_BEAT);
    assign bmem_addr  = {line_addr, {OFF_W{1'b0}}};
    assign bmem_wdata = (state == WR_BEAT) ? dfp_wdata[cnt*BEAT_W +: BEAT_W] : '0;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed and randomized line transfers checked against a cycle-level transaction model.
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;
    logic         err;

    int   vectors     = 0;
    int   miscompares = 0;
    logic exp_err     = 1'b0;

    always #5 clk = ~clk;

    cacheline_adapter dut (
        .clk         (clk),
        .rst         (rst),
        .dfp_addr    (dfp_addr),
        .dfp_read    (dfp_read),
        .dfp_write   (dfp_write),
        .dfp_wdata   (dfp_wdata),
        .dfp_rdata   (dfp_rdata),
        .dfp_resp    (dfp_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid),
        .err         (err)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One complete line transfer. For reads, d is what memory returns; for writes, the line sent.
    // Expected behaviour is tracked per cycle: which bmem strobe should be high, which beat is due,
    // and in which cycle the single dfp_resp must appear.
    task automatic xfer(input bit is_wr, input bit both, input logic [31:0] a, input logic [255:0] d,
                        input int ready_pct, input int gap_pct, input bit use_pat,
                        input logic [7:0] pat, input bit inject, output int resp_cyc);
        int   wcount   = 0;
        int   wcyc     = 0;
        int   sent     = 0;
        int   exp_resp = -1;
        bit   accepted = 0;
        bit   mem_on   = 0;
        bit   need_inj = inject;
        bit   exp_wr;
        bit   exp_rd;
        bit   beat_real;
        bit   beat_bad;
        resp_cyc  = -1;
        dfp_addr  = a;
        dfp_write = is_wr;
        dfp_read  = !is_wr || both;
        dfp_wdata = is_wr ? d : rand_line();
        for (int cyc = 0; cyc < 300; cyc++) begin
            beat_real = 0;
            beat_bad  = 0;
            exp_wr = is_wr && cyc >= 1 && wcount < 4;
            exp_rd = !is_wr && cyc >= 1 && !accepted;
            if (use_pat) bmem_ready = exp_wr ? ((wcyc < 8) ? pat[wcyc] : 1'b1) : 1'b1;
            else         bmem_ready = ($urandom_range(99) < ready_pct);
            if (mem_on) begin
                if ($urandom_range(99) >= gap_pct) begin
                    bmem_rvalid = 1'b1;
                    bmem_rdata  = d[sent*64 +: 64];
                    if (need_inj) begin
                        bmem_raddr = a ^ 32'h0000_0400;
                        beat_bad   = 1;
                        need_inj   = 0;
                    end else begin
                        bmem_raddr = {a[31:5], 5'($urandom)};
                        beat_real  = 1;
                    end
                end else begin
                    bmem_rvalid = 1'b0;
                    bmem_rdata  = {$urandom, $urandom};
                end
            end else begin
                // Stray beats outside the data phase must be ignored by the adapter.
                bmem_rvalid = (gap_pct > 0) && ($urandom_range(3) == 0);
                bmem_rdata  = {$urandom, $urandom};
                bmem_raddr  = $urandom;
            end
            #1;
            chk("bmem_write", bmem_write, exp_wr);
            chk("bmem_read", bmem_read, exp_rd);
            if (exp_wr || exp_rd) chk("bmem_addr", bmem_addr, {a[31:5], 5'b0});
            if (exp_wr) chk("bmem_wdata", bmem_wdata, d[wcount*64 +: 64]);
            chk("dfp_resp", dfp_resp, cyc == exp_resp);
            if (dfp_resp) begin
                resp_cyc = cyc;
                if (!is_wr) chk("dfp_rdata", dfp_rdata, d);
            end
            if (exp_wr) begin
                wcyc++;
                if (bmem_ready) begin
                    wcount++;
                    if (wcount == 4) exp_resp = cyc + 1;
                end
            end
            if (exp_rd && bmem_ready) begin
                accepted = 1;
                mem_on   = 1;
            end
            if (beat_bad) exp_err = 1'b1;
            if (beat_real) begin
                sent++;
                if (sent == 4) begin
                    exp_resp = cyc + 1;
                    mem_on   = 0;
                end
            end
            @(posedge clk);
            #0;
            if (resp_cyc >= 0) break;
        end
        #1;
        chk("resp_seen", resp_cyc >= 0, 1'b1);
        dfp_read    = 1'b0;
        dfp_write   = 1'b0;
        bmem_rvalid = 1'b0;
        bmem_ready  = 1'b0;
        chk("err", err, exp_err);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_dfp_resp", dfp_resp, 1'b0);
        chk("rst_dfp_rdata", dfp_rdata, 256'd0);
        chk("rst_bmem_read", bmem_read, 1'b0);
        chk("rst_bmem_write", bmem_write, 1'b0);
        chk("rst_bmem_addr", bmem_addr, 32'd0);
        chk("rst_bmem_wdata", bmem_wdata, 64'd0);
        chk("rst_err", err, 1'b0);
    endtask

    initial begin
        logic [255:0] line;
        int           rc;
        rst         = 1'b0;
        dfp_addr    = '0;
        dfp_read    = 1'b0;
        dfp_write   = 1'b0;
        dfp_wdata   = '0;
        bmem_ready  = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        bmem_rvalid = 1'b0;
        tick();
        tick();
        chk_reset_outputs();
        rst = 1'b1;
        tick();

        // Ideal read: four back-to-back beats, response at cycle 6 after the request cycle.
        line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        xfer(0, 0, 32'h1234_5678, line, 100, 0, 0, 8'h00, 0, rc);
        chk("read_latency", rc, 6);

        // Ideal write: four accepted beats, response at cycle 5.
        xfer(1, 0, 32'hCAFE_0020, rand_line(), 100, 0, 0, 8'h00, 0, rc);
        chk("write_latency", rc, 5);

        // Write with ready 1,0,1,1,0,1: last beat accepted on write cycle 5 -> resp at cycle 7.
        xfer(1, 0, 32'h8000_1FFF, rand_line(), 0, 0, 1, 8'b0010_1101, 0, rc);
        chk("write_stall_latency", rc, 7);

        // Eviction followed directly by allocation.
        xfer(1, 0, 32'h0000_4040, rand_line(), 70, 0, 0, 8'h00, 0, rc);
        xfer(0, 0, 32'h0000_8080, rand_line(), 70, 30, 0, 8'h00, 0, rc);

        // Both requests high: write goes first, then the read.
        xfer(1, 1, 32'h5555_AAA0, rand_line(), 80, 0, 0, 8'h00, 0, rc);
        xfer(0, 0, 32'h5555_AAA0, rand_line(), 80, 20, 0, 8'h00, 0, rc);

        // Reset after two read beats: abort, discard trailing beats, no response.
        dfp_addr   = 32'hABCD_EF40;
        dfp_read   = 1'b1;
        tick();
        bmem_ready = 1'b1;
        tick();
        bmem_ready  = 1'b0;
        bmem_rvalid = 1'b1;
        bmem_raddr  = 32'hABCD_EF40;
        bmem_rdata  = 64'hAAAA_AAAA_AAAA_AAAA;
        tick();
        bmem_rdata  = 64'hBBBB_BBBB_BBBB_BBBB;
        tick();
        bmem_rvalid = 1'b0;
        dfp_read    = 1'b0;
        rst         = 1'b0;
        tick();
        chk_reset_outputs();
        rst         = 1'b1;
        bmem_rvalid = 1'b1;
        bmem_rdata  = 64'hCCCC_CCCC_CCCC_CCCC;
        tick();
        chk("abort_no_resp", dfp_resp, 1'b0);
        chk("abort_idle", bmem_read, 1'b0);
        bmem_rdata  = 64'hDDDD_DDDD_DDDD_DDDD;
        tick();
        chk("abort_no_resp2", dfp_resp, 1'b0);
        chk("abort_rdata", dfp_rdata, 256'd0);
        bmem_rvalid = 1'b0;
        exp_err     = 1'b0;
        xfer(0, 0, 32'hABCD_EF40, rand_line(), 100, 0, 0, 8'h00, 0, rc);
        chk("clean_read_latency", rc, 6);

        // Random mix of transfers with random ready/rvalid gaps.
        for (int i = 0; i < 24; i++) begin
            xfer($urandom_range(1), $urandom_range(1), $urandom, rand_line(),
                 $urandom_range(30, 100), $urandom_range(0, 60), 0, 8'h00, 0, rc);
        end

`ifdef CLA_RADDR_CHECK_EN
        // One beat with a foreign burst tag is dropped and err latches.
        xfer(0, 0, 32'h0F0F_0F00, rand_line(), 100, 0, 0, 8'h00, 1, rc);
        chk("mismatch_latency", rc, 7);
        xfer(0, 0, 32'h7070_7060, rand_line(), 60, 30, 0, 8'h00, 0, rc);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
